tt_um_colorflyx_spi_regs: RTL and testbench



---
 rtl/tt_um_colorflyx_spi_regs.sv | 161 ++++++++++++++++
 tb/tb_tt_um_colorflyx_spi_regs.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_colorflyx_spi_regs.sv
// SPI mode-0 slave driving a four-entry register file behind the Tiny Tapeout pins.
// Optional feature macro: SPI_AUTOINC_EN (burst transfers with address auto-increment).
module tt_um_colorflyx_spi_regs (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

  state_e      r_state, w_state_next;
  logic [1:0]  r_sck_sync, r_mosi_sync, r_csn_sync;
  logic        r_sck_prev, r_csn_prev;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_shift_in;
  logic [7:0]  r_shift_out;
  logic        r_write;
  logic [1:0]  r_addr;
  logic [7:0]  r_reg0, r_reg1, r_reg2, r_wcnt;

  logic        w_sck, w_mosi, w_csn;
  logic        w_sck_rise, w_sck_fall, w_cs_fall, w_abort;
  logic        w_data_phase, w_byte_done, w_shift_en, w_cmd_done, w_data_end, w_commit;
  logic        w_miso;
  logic [7:0]  w_in_byte;
  logic [1:0]  w_addr_next;
  logic [31:0] w_regs;
  logic        w_unused;

  function automatic logic [7:0] f_reg_mux(input logic [1:0] sel, input logic [31:0] regs);
    return regs[8*sel +: 8];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sck_sync  <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_csn_sync  <= 2'b11;
      r_sck_prev  <= 1'b0;
      r_csn_prev  <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], ui_in[0]};
      r_mosi_sync <= {r_mosi_sync[0], ui_in[1]};
      r_csn_sync  <= {r_csn_sync[0], ui_in[2]};
      r_sck_prev  <= r_sck_sync[1];
      r_csn_prev  <= r_csn_sync[1];
    end
  end

  assign w_sck      = r_sck_sync[1];
  assign w_mosi     = r_mosi_sync[1];
  assign w_csn      = r_csn_sync[1];
  assign w_sck_rise = w_sck & ~r_sck_prev;
  assign w_sck_fall = ~w_sck & r_sck_prev;
  assign w_cs_fall  = ~w_csn & r_csn_prev;
  // CS_N high (or deselect) outranks any SCK edge seen in the same cycle
  assign w_abort    = w_csn | ~ena;

`ifdef SPI_AUTOINC_EN
  assign w_data_phase = (r_state == StData) || (r_state == StDone);
`else
  assign w_data_phase = (r_state == StData);
`endif

  assign w_in_byte   = {r_shift_in, w_mosi};
  assign w_byte_done = w_sck_rise & (r_bit_cnt == 3'd7);
  assign w_shift_en  = ~w_abort & w_sck_rise & ((r_state == StCmd) | w_data_phase);
  assign w_cmd_done  = w_shift_en & (r_state == StCmd) & (r_bit_cnt == 3'd7);
  assign w_data_end  = w_shift_en & w_data_phase & (r_bit_cnt == 3'd7);
  assign w_commit    = w_data_end & r_write;
  assign w_addr_next = r_addr + 2'd1;
  assign w_regs      = {r_wcnt, r_reg2, r_reg1, r_reg0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_abort) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (w_cs_fall) w_state_next = StCmd;
        StCmd:   if (w_byte_done) w_state_next = StData;
        StData:  if (w_byte_done) w_state_next = StDone;
        StDone:  w_state_next = StDone;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin
    w_miso = 1'b0;
    if (w_data_phase && !r_write) w_miso = r_shift_out[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= 3'd0;
      r_shift_in  <= 7'd0;
      r_shift_out <= 8'd0;
      r_write     <= 1'b0;
      r_addr      <= 2'd0;
    end else begin
      if (r_state == StIdle) begin
        r_bit_cnt <= 3'd0;
      end else if (w_shift_en) begin
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        r_shift_in <= w_in_byte[6:0];
      end

      if (w_cmd_done) begin
        r_write     <= w_in_byte[7];
        r_addr      <= w_in_byte[1:0];
        r_shift_out <= f_reg_mux(w_in_byte[1:0], w_regs);
`ifdef SPI_AUTOINC_EN
      end else if (w_data_end) begin
        r_addr      <= w_addr_next;
        r_shift_out <= f_reg_mux(w_addr_next, w_regs);
`endif
      end else if (w_sck_fall && w_data_phase && !w_abort) begin
        r_shift_out <= {r_shift_out[6:0], 1'b0};
      end
    end
  end

  // REG3 is the write counter; data aimed at it is dropped but still counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg0 <= 8'd0;
      r_reg1 <= 8'd0;
      r_reg2 <= 8'd0;
      r_wcnt <= 8'd0;
    end else if (w_commit) begin
      case (r_addr)
        2'd0:    r_reg0 <= w_in_byte;
        2'd1:    r_reg1 <= w_in_byte;
        2'd2:    r_reg2 <= w_in_byte;
        default: ;
      endcase
      r_wcnt <= r_wcnt + 8'd1;
    end
  end

  assign uo_out  = r_reg0;
  assign uio_out = {w_miso, r_reg1[6:0]};
  assign uio_oe  = {1'b1, r_reg2[6:0]};

  assign w_unused = &{1'b0, ui_in[7:3], uio_in};

endmodule

// File: tb/tb_tt_um_colorflyx_spi_regs.sv
// Randomized self-checking bench for tt_um_colorflyx_spi_regs against a byte-level
// register model; honours SPI_AUTOINC_EN when defined.
module tb_tt_um_colorflyx_spi_regs;

  localparam int Half = 5;  // SCK half-period in clk cycles

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks;
  int n_errors;

  logic [7:0] mdl [4];  // mdl[3] is the write counter
  logic [7:0] snap_uo, snap_uio, snap_oe;

  tt_um_colorflyx_spi_regs u_dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one CS_N-low frame of nbits bits taken MSB-first from tx.
  // rx[63-r] holds MISO sampled late in the high phase after rise r.
  task automatic spi_frame(input logic [63:0] tx, input int nbits,
                           output logic [63:0] rx, output logic miso_bad);
    rx = '0;
    miso_bad = 1'b0;
    ui_in[2] = 1'b0;
    wait_clk(Half);
    for (int i = 0; i < nbits; i++) begin
      ui_in[1] = tx[63-i];
      ui_in[0] = 1'b0;
      wait_clk(Half);
      ui_in[0] = 1'b1;
      if (i == nbits - 1) begin
        wait_clk(4);
        snap_uo  = uo_out;
        snap_uio = uio_out;
        snap_oe  = uio_oe;
        wait_clk(Half - 4);
      end else begin
        wait_clk(Half);
      end
      if (i + 1 >= 8 && i + 1 < 64) rx[63-(i+1)] = uio_out[7];
      if (uio_out[7] && (i < 7 || tx[63])) miso_bad = 1'b1;
    end
    ui_in[0] = 1'b0;
    wait_clk(Half);
    ui_in[2] = 1'b1;
    wait_clk(6);
  endtask

  // Run a frame on the DUT and the model, then compare read data and outputs.
  task automatic do_frame(input logic [63:0] tx, input int nbits, output logic [7:0] rd_byte);
    logic [63:0] rx;
    logic        miso_bad;
    logic        wr;
    logic [1:0]  addr;
    logic [1:0]  a;
    logic [7:0]  exp_rd;
    int          nb;
    wr   = tx[63];
    addr = tx[57:56];
    nb   = 0;
    if (ena && nbits >= 16) begin
`ifdef SPI_AUTOINC_EN
      nb = nbits / 8 - 1;
`else
      nb = 1;
`endif
    end
    exp_rd = mdl[addr];
    spi_frame(tx, nbits, rx, miso_bad);
    if (wr) begin
      for (int k = 1; k <= nb; k++) begin
        a = addr + 2'(k - 1);
        if (a != 2'd3) mdl[a] = tx[63-8*k -: 8];
        mdl[3] = mdl[3] + 8'd1;
      end
    end
    rd_byte = rx[55:48];
    check_eq("miso_quiet", {7'd0, miso_bad}, 8'h00);
    if (!wr && nb > 0) check_eq("rd_data", rd_byte, exp_rd);
    check_eq("uo_out", snap_uo, mdl[0]);
    check_eq("uio_out", {1'b0, snap_uio[6:0]}, {1'b0, mdl[1][6:0]});
    check_eq("uio_oe", snap_oe, {1'b1, mdl[2][6:0]});
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
    do_frame({6'd0, a, 56'd0}, 16, d);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] v);
    logic [7:0] d;
    do_frame({1'b1, 5'd0, a, v, 48'd0}, 16, d);
  endtask

  initial begin
    logic [7:0] d;
    int         n;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h04;
    uio_in = 8'h00;
    wait_clk(4);
    check_eq("rst_uo_out", uo_out, 8'h00);
    check_eq("rst_uio_out", uio_out, 8'h00);
    check_eq("rst_uio_oe", uio_oe, 8'h80);
    rst_n = 1'b1;
    wait_clk(4);

    rd_reg(2'd3, d);
    check_eq("reg3_reset", d, 8'h00);

    wr_reg(2'd0, 8'hA5);
    check_eq("reg0_a5_4clk", snap_uo, 8'hA5);
    rd_reg(2'd3, d);
    check_eq("reg3_one", d, 8'h01);

    wr_reg(2'd2, 8'h0F);
    wr_reg(2'd1, 8'h55);
    check_eq("uio_oe_8f", uio_oe, 8'h8F);
    check_eq("uio_out_55", {1'b0, uio_out[6:0]}, 8'h55);
    rd_reg(2'd1, d);
    check_eq("rd_reg1_55", d, 8'h55);
    rd_reg(2'd3, d);
    check_eq("reg3_three", d, 8'h03);

    // Frame cut after 12 bits must leave everything untouched
    do_frame({8'h81, 8'hFF, 48'd0}, 12, d);
    rd_reg(2'd1, d);
    check_eq("abort_reg1", d, 8'h55);
    rd_reg(2'd3, d);
    check_eq("abort_reg3", d, 8'h03);
    wr_reg(2'd1, 8'h3C);
    check_eq("after_abort_wr", {1'b0, uio_out[6:0]}, 8'h3C);

    ena = 1'b0;
    wr_reg(2'd0, 8'h77);
    ena = 1'b1;
    wait_clk(2);
    check_eq("ena_low_reg0", uo_out, 8'hA5);
    rd_reg(2'd3, d);
    check_eq("ena_low_reg3", d, 8'h04);

    for (int t = 0; t < 40; t++) begin
      logic [63:0] tx;
      int          nbits;
      tx    = {$urandom, $urandom};
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      ena   = ($urandom_range(0, 7) != 0);
      do_frame(tx, nbits, d);
      ena = 1'b1;
      wait_clk(2);
    end

    n = 256 - int'(mdl[3]);
    for (int t = 0; t < n; t++) wr_reg(2'd3, 8'($urandom));
    rd_reg(2'd3, d);
    check_eq("reg3_wrap", d, 8'h00);

    // Reset in the middle of a frame clears everything
    ui_in[2] = 1'b0;
    wait_clk(Half);
    for (int i = 0; i < 5; i++) begin
      ui_in[1] = 1'b1;
      ui_in[0] = 1'b1;
      wait_clk(Half);
      ui_in[0] = 1'b0;
      wait_clk(Half);
    end
    rst_n = 1'b0;
    wait_clk(2);
    check_eq("midrst_uo_out", uo_out, 8'h00);
    check_eq("midrst_uio_out", uio_out, 8'h00);
    check_eq("midrst_uio_oe", uio_oe, 8'h80);
    ui_in = 8'h04;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    rd_reg(2'd3, d);
    check_eq("midrst_reg3", d, 8'h00);
    rd_reg(2'd0, d);
    check_eq("midrst_reg0", d, 8'h00);

`ifdef SPI_AUTOINC_EN
    do_frame({8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 24'd0}, 40, d);
    check_eq("burst_reg0", uo_out, 8'h11);
    check_eq("burst_reg1", {1'b0, uio_out[6:0]}, 8'h22);
    check_eq("burst_reg2", uio_oe, 8'hB3);
    rd_reg(2'd3, d);
    check_eq("burst_reg3", d, 8'h04);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
